// File: rtl/serializer_n_pkg.sv
// Shared types for the word-to-element serializer.
// Holds the two-state control encoding.
package serializer_n_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } serState_t;

endpackage

// File: rtl/serializer_n.sv
// Streaming width converter: one SIZE-element word in,
// SIZE WIDTH-bit elements out, element 0 first.
module serializer_n
    import serializer_n_pkg::*;
#(
    parameter int SIZE  = 8,
    parameter int WIDTH = 32
) (
    input  logic                  iCLK,
    input  logic                  iRST_n,
    input  logic                  iValid_AS,
    output logic                  oReady_AS,
    input  logic [SIZE*WIDTH-1:0] iData_AS,
    output logic                  oValid_BM,
    input  logic                  iReady_BM,
    output logic [WIDTH-1:0]      oData_BM,
    output logic                  oLast_BM
);

    localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(SIZE - 1);

    serState_t             rState;
    serState_t             nState;
    logic [SIZE*WIDTH-1:0] rBuf;
    logic [SIZE*WIDTH-1:0] nBuf;
    logic [CW-1:0]         rCnt;
    logic [CW-1:0]         nCnt;
    logic                  rEn;
    logic                  busy;
    logic                  lastEl;
    logic                  fireI;
    logic                  fireO;

    assign busy   = (rState == BUSY);
    assign lastEl = busy && (rCnt == LAST_IDX);
    assign fireO  = busy && iReady_BM;

    // Ready looks through to iReady_BM so a new word can land on the last beat.
    assign oReady_AS = rEn && (!busy || (iReady_BM && lastEl));
    assign fireI     = iValid_AS && oReady_AS;

    assign oValid_BM = busy;
    assign oData_BM  = rBuf[WIDTH-1:0];
    assign oLast_BM  = lastEl;

    always_comb begin
        nState = rState;
        nBuf   = rBuf;
        nCnt   = rCnt;
        unique case (rState)
            IDLE: begin
                if (fireI) begin
                    nBuf   = iData_AS;
                    nCnt   = '0;
                    nState = BUSY;
                end
            end
            BUSY: begin
                if (fireO) begin
                    if (!lastEl) begin
                        nBuf = rBuf >> WIDTH;
                        nCnt = rCnt + CW'(1);
                    end else if (fireI) begin
                        nBuf = iData_AS;
                        nCnt = '0;
                    end else begin
                        nCnt   = '0;
                        nState = IDLE;
                    end
                end
            end
            default: nState = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            rState <= IDLE;
            rBuf   <= '0;
            rCnt   <= '0;
            rEn    <= 1'b0;
        end else begin
            rState <= nState;
            rBuf   <= nBuf;
            rCnt   <= nCnt;
            rEn    <= 1'b1;
        end
    end

endmodule
